dmem_port: RTL and testbench

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/dmem_port.sv | 145 ++++++++++++++
 tb/tb_dmem_port.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// dmem_port: data-memory port with word/byte RAM, TX FIFO and MMIO status/cycle registers.
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   reset      in   1   asynchronous active-low reset
//   MemWriteM  in   1   store strobe for the memory-stage access
//   MemByteM   in   1   1 = byte access (LDRB/STRB), 0 = word access
//   ALUOutM    in  32   byte address of the access
//   WriteDataM in  32   store data
//   ReadDataM  out 32   load data, combinational from the current address
//   tx_data    out 32   TX FIFO head word
//   tx_valid   out  1   TX FIFO non-empty
//   tx_ready   in   1   consumer accepts the head word
//   err        out  1   sticky unmapped-access flag
//
// Memory map: RAM below 4*RAM_WORDS, TXDATA 0x100, STATUS 0x104, CYCLE 0x108.
module dmem_port #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemByteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);

    localparam int          RW        = $clog2(RAM_WORDS);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic        r_ovf;
    logic        r_err;
    logic [31:0] r_cyc;

    logic        w_is_ram;
    logic        w_is_tx;
    logic        w_is_st;
    logic        w_is_cyc;
    logic        w_unmapped;
    logic        w_aligned;
    logic [RW-1:0] w_idx;
    logic [1:0]  w_lane;
    logic [31:0] w_word;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [31:0] w_status;
    logic        w_empty;
    logic        w_full;
    logic        w_tx_st;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_clr;

    // Address decode; MMIO registers only match word-aligned addresses,
    // so a misaligned MMIO access falls through to unmapped.
    assign w_aligned  = ALUOutM[1:0] == 2'b00;
    assign w_is_ram   = ALUOutM < RAM_BYTES;
    assign w_is_tx    = !w_is_ram && w_aligned && ALUOutM == 32'h0000_0100;
    assign w_is_st    = !w_is_ram && w_aligned && ALUOutM == 32'h0000_0104;
    assign w_is_cyc   = !w_is_ram && w_aligned && ALUOutM == 32'h0000_0108;
    assign w_unmapped = !w_is_ram && !w_is_tx && !w_is_st && !w_is_cyc;

    // RAM read path: little-endian lane select for byte loads.
    assign w_idx   = ALUOutM[RW+1:2];
    assign w_lane  = ALUOutM[1:0];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};
    assign w_byte  = w_shift[7:0];

    // FIFO handshake; a store while full is accepted only if a pop frees a slot.
    assign w_empty   = r_cnt == '0;
    assign w_full    = r_cnt == CW'(FIFO_DEPTH);
    assign w_pop     = tx_valid && tx_ready;
    assign w_tx_st   = MemWriteM && w_is_tx;
    assign w_push    = w_tx_st && (!w_full || w_pop);
    assign w_ovf_set = w_tx_st && w_full && !w_pop;
    assign w_clr     = MemWriteM && w_is_st;

    assign tx_valid = !w_empty;
    assign tx_data  = r_fifo[r_rp];
    assign err      = r_err;

    always_comb begin
        w_status          = '0;
        w_status[0]       = w_empty;
        w_status[1]       = w_full;
        w_status[2]       = r_ovf;
        w_status[3 +: CW] = r_cnt;
        w_status[15]      = r_err;
    end

    // TXDATA loads and unmapped loads fall through to zero.
    assign ReadDataM = w_is_ram ? (MemByteM ? {24'h0, w_byte} : w_word) :
                       w_is_st  ? w_status :
                       w_is_cyc ? r_cyc : 32'h0;

    // RAM and FIFO storage are not reset; reads use pre-store contents.
    always_ff @(posedge clk) begin
        if (MemWriteM && w_is_ram) begin
            if (MemByteM)
                r_mem[w_idx][{w_lane, 3'b000} +: 8] <= WriteDataM[7:0];
            else
                r_mem[w_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wp] <= WriteDataM;
    end

    // Set events win over a same-cycle STATUS clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
            r_cyc <= 32'h0;
        end else begin
            r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_ovf <= w_ovf_set ? 1'b1 : w_clr ? 1'b0 : r_ovf;
            r_err <= w_unmapped ? 1'b1 : w_clr ? 1'b0 : r_err;
            r_cyc <= (MemWriteM && w_is_cyc) ? WriteDataM : r_cyc + 32'h1;
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed self-checking bench for dmem_port.
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemByteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    dmem_port dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemByteM   (MemByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic by, input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = we;
        MemByteM   = by;
        ALUOutM    = a;
        WriteDataM = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        tx_ready = 1'b0;
        drive(0, 0, 32'h0, 32'h0);
        #11;
        check("rst_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        tick();
        reset = 1'b1;
        drive(0, 0, 32'h104, 32'h0);
        check("rst_status", ReadDataM, 32'h0000_0001);

        drive(1, 0, 32'h10, 32'hDEAD_BEEF);
        tick();
        drive(0, 0, 32'h10, 32'h0);
        check("ld_word", ReadDataM, 32'hDEAD_BEEF);
        drive(0, 1, 32'h12, 32'h0);
        check("ld_byte2", ReadDataM, 32'h0000_00AD);
        drive(1, 0, 32'h10, 32'h1122_3344);
        check("ld_prestore", ReadDataM, 32'hDEAD_BEEF);
        tick();
        drive(1, 1, 32'h13, 32'hAAAA_AA55);
        tick();
        drive(0, 0, 32'h10, 32'h0);
        check("strb_word", ReadDataM, 32'h5522_3344);
        drive(0, 1, 32'h10, 32'h0);
        check("ld_byte0", ReadDataM, 32'h0000_0044);

        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 32'h100, 32'hA000_0000 + 32'(i));
            tick();
        end
        drive(0, 0, 32'h104, 32'h0);
        check("ovf_status", ReadDataM, 32'h0000_0026);
        check("ovf_valid", {31'b0, tx_valid}, 32'h1);
        drive(0, 0, 32'h100, 32'h0);
        check("txdata_load", ReadDataM, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("pop_order", tx_data, 32'hA000_0000 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("drained", {31'b0, tx_valid}, 32'h0);
        drive(0, 0, 32'h104, 32'h0);
        check("ovf_sticky", ReadDataM, 32'h0000_0005);
        drive(1, 0, 32'h104, 32'h0);
        tick();
        drive(0, 0, 32'h104, 32'h0);
        check("ovf_clear", ReadDataM, 32'h0000_0001);

        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 32'h100, 32'hB000_0000 + 32'(i));
            tick();
        end
        tx_ready = 1'b1;
        drive(1, 0, 32'h100, 32'hB000_0005);
        tick();
        tx_ready = 1'b0;
        drive(0, 0, 32'h104, 32'h0);
        check("pushpop_status", ReadDataM, 32'h0000_0022);
        check("pushpop_head", tx_data, 32'hB000_0002);
        drive(0, 0, 32'h0, 32'h0);
        tx_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("pushpop_order", tx_data, 32'hB000_0000 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("pushpop_empty", {31'b0, tx_valid}, 32'h0);

        drive(1, 0, 32'h108, 32'hFFFF_FFFE);
        tick();
        drive(0, 0, 32'h108, 32'h0);
        tick();
        check("cyc_ff", ReadDataM, 32'hFFFF_FFFF);
        tick();
        check("cyc_wrap", ReadDataM, 32'h0000_0000);
        tick();
        check("cyc_one", ReadDataM, 32'h0000_0001);

        drive(0, 0, 32'h200, 32'h0);
        check("unm_data", ReadDataM, 32'h0);
        tick();
        check("unm_err", {31'b0, err}, 32'h1);
        drive(0, 0, 32'h104, 32'h0);
        check("unm_status", ReadDataM, 32'h0000_8001);
        drive(1, 0, 32'h104, 32'h0);
        tick();
        drive(0, 0, 32'h0, 32'h0);
        check("err_clear", {31'b0, err}, 32'h0);
        drive(0, 0, 32'h106, 32'h0);
        check("misalign_data", ReadDataM, 32'h0);
        tick();
        check("misalign_err", {31'b0, err}, 32'h1);
        drive(1, 0, 32'h104, 32'h0);
        tick();

        drive(1, 0, 32'h100, 32'hC000_0001);
        tick();
        drive(1, 0, 32'h100, 32'hC000_0002);
        tick();
        drive(0, 0, 32'h0, 32'h0);
        check("pre_arst_valid", {31'b0, tx_valid}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, tx_valid}, 32'h0);
        reset = 1'b1;
        tick();
        drive(0, 0, 32'h104, 32'h0);
        check("arst_status", ReadDataM, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
